debug_uart_tx: RTL and testbench
================================

DEBUG_UART_TX -- requirements
Module: debug_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving byte FIFO depth; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_Data  input  8  byte produced by the core's debug path.
REQ-006 tx_DataValid  input  1  one-cycle-per-byte write strobe; byte accepted when tx_DataValid=1 and tx_Ready=1.
REQ-007 tx_Ready  output  1  FIFO not full.
REQ-008 uart_txd  output  1  serial line, idle high.
REQ-009 tx_Busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the frame in flight.
REQ-011 overflow  output  1  sticky flag; set when tx_DataValid=1 while tx_Ready=0.

Function
REQ-012 Frame SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-026), 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty; START->DATA, DATA->(PARITY or STOP) after bit 7, PARITY->STOP, STOP->IDLE, each after a full bit period.
REQ-014 Leaving IDLE SHALL pop one byte into the shift register in the same cycle; uart_txd SHALL go low on the following cycle.
REQ-015 If the FIFO is non-empty at the end of STOP, the block SHALL go to START in the next cycle with no extra idle bit (back-to-back frames).
REQ-016 A write attempted while full SHALL be dropped, leave FIFO contents unchanged, and set overflow; overflow clears only on reset.
REQ-017 Simultaneous push and pop with FIFO full SHALL be treated as full (push dropped); with FIFO empty, pop cannot occur, push is accepted.
REQ-018 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-019 tx_Ready SHALL be registered-path combinational from fifo_count (fifo_count != FIFO_DEPTH), valid in the same cycle.
REQ-020 Bit-period counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and reset to 0 on every bit boundary.
REQ-021 tx_DataValid SHALL be ignored during reset.

Reset
REQ-022 On reset: FSM=IDLE, uart_txd=1, FIFO pointers and fifo_count=0, tx_Ready=1, tx_Busy=0, overflow=0, bit counter=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame: uart_txd=1 from the cycle after the reset edge; queued bytes discarded.
REQ-024 No output SHALL be X after the first reset clock edge.

Configuration
REQ-025 Macro DEBUG_UART_PARITY_EN SHALL control the parity bit.
REQ-026 With DEBUG_UART_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is sent in PARITY; frame = 11 bits.
REQ-027 Without DEBUG_UART_PARITY_EN: PARITY state is not built; DATA->STOP directly; frame = 10 bits.

Verification
REQ-028 CLKS_PER_BIT=4, no parity: push 0x55 -> line low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; total 40 cycles; tx_Busy falls after stop.
REQ-029 Push 0xA5, 0x3C on consecutive cycles -> two frames back-to-back, second start bit immediately after first stop bit, fifo_count 1->0 at second pop.
REQ-030 FIFO_DEPTH=8: push 10 bytes in 10 consecutive cycles while first frame shifts -> bytes 1..9 accepted (one popped), byte 10 dropped, overflow=1, 9 correct frames emitted.
REQ-031 Assert reset during DATA bit 3 of 0xFF -> uart_txd=1 next cycle, fifo_count=0, tx_Busy=0, no further frame output.
REQ-032 With DEBUG_UART_PARITY_EN, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
REQ-033 Hold tx_DataValid=1 during reset -> no byte queued, fifo_count=0 after reset release.

Source files
------------

// File: rtl/debug_uart_tx_if.sv
// debug_uart_tx_if -- byte write channel into the debug UART transmitter.
//   tx_Data      : byte from the core's debug path
//   tx_DataValid : one-cycle-per-byte write strobe
//   tx_Ready     : transmitter FIFO not full (byte taken when valid & ready)
// master = byte producer, slave = debug_uart_tx.
interface debug_uart_tx_if;
  logic [7:0] tx_Data;
  logic       tx_DataValid;
  logic       tx_Ready;

  modport master (output tx_Data, output tx_DataValid, input  tx_Ready);
  modport slave  (input  tx_Data, input  tx_DataValid, output tx_Ready);
endinterface

// File: rtl/debug_uart_tx.sv
// debug_uart_tx -- byte FIFO feeding an 8N1 (or 8E1) UART transmitter.
// Optional feature: define DEBUG_UART_PARITY_EN to send an even-parity bit
// between the data bits and the stop bit (11-bit frame instead of 10).
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous active-high reset
//   s_if       : slave side of the byte write channel (tx_Data/tx_DataValid/tx_Ready)
//   uart_txd   : serial line, idle high
//   tx_Busy    : frame being shifted or bytes still queued
//   fifo_count : bytes queued, not counting the frame in flight
//   overflow   : sticky, a write was attempted while the FIFO was full
module debug_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  debug_uart_tx_if.slave              s_if,
  output logic                        uart_txd,
  output logic                        tx_Busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef DEBUG_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  // transmitter state
  state_t        r_state, w_state_next;
  logic [15:0]   r_bit_cnt, w_bit_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_txd, w_txd_next;
`ifdef DEBUG_UART_PARITY_EN
  logic          r_parity;
`endif

  logic w_full, w_not_empty, w_push, w_pop, w_bit_done;

  assign w_full      = (r_count == FULL);
  assign w_not_empty = (r_count != '0);
  // Full wins over a same-cycle pop: the write is dropped even if a byte leaves.
  assign w_push      = s_if.tx_DataValid && !w_full;
  assign w_bit_done  = (r_bit_cnt == BIT_LAST);

  assign s_if.tx_Ready = !w_full;
  assign uart_txd      = r_txd;
  assign tx_Busy       = (r_state != IDLE) || w_not_empty;
  assign fifo_count    = r_count;
  assign overflow      = r_overflow;

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    w_txd_next     = r_txd;

    // bit-period counter runs in every non-idle state and restarts at each boundary
    if (r_state != IDLE) w_bit_cnt_next = w_bit_done ? 16'd0 : r_bit_cnt + 16'd1;

    case (r_state)
      IDLE: begin
        if (w_not_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_next   = DATA;
          w_bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef DEBUG_UART_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef DEBUG_UART_PARITY_EN
      PARITY: begin
        if (w_bit_done) w_state_next = STOP;
      end
`endif
      STOP: begin
        // chain straight into the next start bit when more bytes are waiting
        if (w_bit_done) begin
          if (w_not_empty) begin
            w_pop        = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_pop) w_shift_next = r_mem[r_rd_ptr];

    // line level is registered from the state being entered, so it changes
    // on the same edge as the state and never glitches
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_next[0];
`ifdef DEBUG_UART_PARITY_EN
      PARITY:  w_txd_next = r_parity;
`endif
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_txd      <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
`ifdef DEBUG_UART_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_txd     <= w_txd_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (s_if.tx_DataValid && w_full) r_overflow <= 1'b1;
`ifdef DEBUG_UART_PARITY_EN
      if (w_pop) r_parity <= ^r_mem[r_rd_ptr];
`endif
    end
  end

  // storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= s_if.tx_Data;
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
module tb_debug_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef DEBUG_UART_PARITY_EN
  localparam int FRAME_CYC = 44;
`else
  localparam int FRAME_CYC = 40;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_txd, tx_Busy, overflow;
  logic [3:0] fifo_count;

  debug_uart_tx_if u_if ();

  debug_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_if(u_if),
    .uart_txd(uart_txd), .tx_Busy(tx_Busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         errs  = 0;
  logic [7:0] sb_q[$];
  int         gen = 0;
  int         rx_frames = 0;
  logic       prev_line = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line receiver: samples each bit in its second cycle, compares against scoreboard.
  always begin : rx
    int         g;
    logic [7:0] d;
    logic       sb, pb, stb;
    @(negedge clk);
    if (!reset && prev_line === 1'b1 && uart_txd === 1'b0) begin
      g = gen;
      pb = 1'b0;
      @(negedge clk); sb = uart_txd;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        d[i] = uart_txd;
      end
`ifdef DEBUG_UART_PARITY_EN
      repeat (CPB) @(negedge clk); pb = uart_txd;
`endif
      repeat (CPB) @(negedge clk); stb = uart_txd;
      if (g == gen) begin
        rx_frames++;
        tests++;
        assert (sb_q.size() != 0) else begin
          errs++;
          $error("FAIL rx_unexpected_frame: observed %0h expected none", d);
        end
        if (sb_q.size() != 0) begin
          logic [7:0] e;
          e = sb_q.pop_front();
          check("rx_start_bit", {31'd0, sb}, 32'd0);
          check("rx_data", {24'd0, d}, {24'd0, e});
`ifdef DEBUG_UART_PARITY_EN
          check("rx_parity", {31'd0, pb}, {31'd0, ^e});
`endif
          check("rx_stop_bit", {31'd0, stb}, 32'd1);
        end
      end
    end
    prev_line = uart_txd;
  end

  task automatic drive(input logic [7:0] b, input bit acc);
    u_if.tx_Data      = b;
    u_if.tx_DataValid = 1'b1;
    check("ready_at_push", {31'd0, u_if.tx_Ready}, {31'd0, acc});
    if (acc) sb_q.push_back(b);
    @(negedge clk);
    u_if.tx_DataValid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (tx_Busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, tx_Busy}, 32'd0);
  endtask

  initial begin
    int lows, busy, n, frames0;
    bit seen_high;

    // reset with a write strobe held high: nothing may be queued
    u_if.tx_Data      = 8'hEE;
    u_if.tx_DataValid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd",      {31'd0, uart_txd}, 32'd1);
    check("rst_ready",    {31'd0, u_if.tx_Ready}, 32'd1);
    check("rst_busy",     {31'd0, tx_Busy}, 32'd0);
    check("rst_count",    {28'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    u_if.tx_DataValid = 1'b0;
    @(negedge clk);
    check("post_rst_count", {28'd0, fifo_count}, 32'd0);
    check("post_rst_busy",  {31'd0, tx_Busy}, 32'd0);

    // single frame 0x55: start low exactly CPB cycles, whole frame FRAME_CYC cycles
    drive(8'h55, 1'b1);
    check("55_count", {28'd0, fifo_count}, 32'd1);
    check("55_busy",  {31'd0, tx_Busy}, 32'd1);
    n = 0;
    while (uart_txd !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("55_start_seen", {31'd0, uart_txd}, 32'd0);
    lows = 0; busy = 0; seen_high = 0;
    for (int k = 0; k < 60; k++) begin
      if (tx_Busy === 1'b1) busy++;
      if (uart_txd === 1'b0 && !seen_high) lows++; else seen_high = 1;
      @(negedge clk);
    end
    check("55_start_len", lows, CPB);
    check("55_frame_len", busy, FRAME_CYC);
    check("55_idle_line", {31'd0, uart_txd}, 32'd1);

    // back-to-back frames 0xA5, 0x3C
    drive(8'hA5, 1'b1);
    drive(8'h3C, 1'b1);
    check("b2b_count_q", {28'd0, fifo_count}, 32'd1);
    busy = 0;
    for (int k = 0; k < 2 * FRAME_CYC + 20; k++) begin
      if (k == 0)             check("b2b_first_start", {31'd0, uart_txd}, 32'd0);
      if (k == FRAME_CYC - 1) begin
        check("b2b_stop_line", {31'd0, uart_txd}, 32'd1);
        check("b2b_stop_count", {28'd0, fifo_count}, 32'd1);
      end
      if (k == FRAME_CYC) begin
        check("b2b_second_start", {31'd0, uart_txd}, 32'd0);
        check("b2b_pop_count", {28'd0, fifo_count}, 32'd0);
      end
      if (tx_Busy === 1'b1) busy++;
      @(negedge clk);
    end
    check("b2b_busy_len", busy, 2 * FRAME_CYC);

    // overflow: 10 consecutive writes, last one dropped
    frames0 = rx_frames;
    for (int i = 0; i < 10; i++) drive(8'h10 + 8'(i), i < 9);
    check("ovf_count", {28'd0, fifo_count}, 32'd8);
    check("ovf_flag",  {31'd0, overflow}, 32'd1);
    check("ovf_ready", {31'd0, u_if.tx_Ready}, 32'd0);
    wait_idle(9 * FRAME_CYC + 50);
    repeat (3) @(negedge clk);
    check("ovf_frames", rx_frames - frames0, 9);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // parity bytes (parity bit checked by the receiver when enabled)
    drive(8'h07, 1'b1);
    drive(8'h03, 1'b1);
    wait_idle(3 * FRAME_CYC);
    repeat (3) @(negedge clk);
    check("par_q_empty", sb_q.size(), 0);

    // reset during data bit 3 of 0xFF with another byte queued
    drive(8'hFF, 1'b1);
    drive(8'h81, 1'b1);
    check("abort_start", {31'd0, uart_txd}, 32'd0);
    repeat (17) @(negedge clk);
    check("abort_mid_line", {31'd0, uart_txd}, 32'd1);
    check("abort_queued", {28'd0, fifo_count}, 32'd1);
    reset = 1'b1;
    gen++;
    sb_q.delete();
    frames0 = rx_frames;
    @(negedge clk);
    check("abort_txd",   {31'd0, uart_txd}, 32'd1);
    check("abort_count", {28'd0, fifo_count}, 32'd0);
    check("abort_busy",  {31'd0, tx_Busy}, 32'd0);
    check("abort_ovf",   {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("abort_no_output", lows, 0);
    check("abort_no_frames", rx_frames - frames0, 0);
    check("final_q_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  // global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
